wb_write_arbiter: RTL and testbench

Writeback-side driver for the register file's single write port. Merges results from the in-order ALU/MEM pipeline, which cannot stall and always has priority, with results from a long-latency unit (mul/div), which are buffered in a small FIFO. Presents one registered write per cycle (`RegWrite`/`rd`/`InputData`) to the register file. Also reports pending-write hazards to the hazard unit, and raises a starvation request when buffered results wait too long.

---
 rtl/wb_write_arbiter_pkg.sv | 18 +
 rtl/wb_fifo.sv | 66 ++++++
 rtl/wb_write_arbiter.sv | 109 ++++++++++
 tb/tb_wb_write_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_write_arbiter_pkg.sv
// Shared widths, the write-record type and small helpers for the writeback arbiter.
package wb_write_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wbWrite_t;

    // Writes to r0 are architecturally dropped, so they never count as real work.
    function automatic logic isRealReg(input logic [REG_ADDR_W-1:0] addr);
        return addr != REG_ZERO;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order buffer for long-latency results; exposes per-entry valid bits and
// destination registers so the parent can report pending writes.
module wb_fifo
    import wb_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                             Clock,
    input  logic                             Reset_n,
    input  logic                             push,
    input  wbWrite_t                         pushEntry,
    input  logic                             pop,
    output wbWrite_t                         headEntry,
    output logic                             full,
    output logic                             empty,
    output logic [DEPTH-1:0]                 entryValid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0] entryRd
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wbWrite_t          mem [DEPTH];
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [CNT_W-1:0]  count;
    logic              doPush;
    logic              doPop;

    assign full   = count == CNT_W'(DEPTH);
    assign empty  = count == '0;
    assign doPush = push && !full;
    assign doPop  = pop && !empty;
    assign headEntry = mem[rdPtr];

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (doPush) mem[wrPtr] <= pushEntry;
    end

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        entryValid = '0;
        entryRd    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entryRd[i]    = mem[i].rd;
            entryValid[i] = CNT_W'(PTR_W'(PTR_W'(i) - rdPtr)) < count;
        end
    end

endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: pipeline writes win, long results queue in wb_fifo.
// Optional starvation guard enabled by defining WB_STARVE_GUARD_EN.
module wb_write_arbiter
    import wb_write_arbiter_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic                  AluValid,
    input  logic [REG_ADDR_W-1:0] AluRd,
    input  logic [DATA_W-1:0]     AluData,
    input  logic                  LongValid,
    input  logic [REG_ADDR_W-1:0] LongRd,
    input  logic [DATA_W-1:0]     LongData,
    output logic                  LongReady,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] rd,
    output logic [DATA_W-1:0]     InputData,
    input  logic [REG_ADDR_W-1:0] QueryRs,
    input  logic [REG_ADDR_W-1:0] QueryRt,
    output logic                  RsPending,
    output logic                  RtPending,
    output logic                  LongStarve,
    output logic                  Full,
    output logic                  Empty
);

    logic                             aluWins;
    logic                             longPush;
    logic                             longPop;
    wbWrite_t                         headEntry;
    logic [DEPTH-1:0]                 entryValid;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] entryRd;
    logic                             rsQueued;
    logic                             rtQueued;

    assign aluWins   = AluValid && isRealReg(AluRd);
    assign LongReady = !Full;
    // r0 long results are accepted (handshake completes) but dropped here.
    assign longPush  = LongValid && LongReady && isRealReg(LongRd);
    assign longPop   = !aluWins && !Empty;

    wb_fifo #(.DEPTH(DEPTH)) fifo (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .push       (longPush),
        .pushEntry  ('{rd: LongRd, data: LongData}),
        .pop        (longPop),
        .headEntry  (headEntry),
        .full       (Full),
        .empty      (Empty),
        .entryValid (entryValid),
        .entryRd    (entryRd)
    );

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            RegWrite  <= 1'b0;
            rd        <= REG_ZERO;
            InputData <= '0;
        end else if (aluWins) begin
            RegWrite  <= 1'b1;
            rd        <= AluRd;
            InputData <= AluData;
        end else if (!Empty) begin
            RegWrite  <= 1'b1;
            rd        <= headEntry.rd;
            InputData <= headEntry.data;
        end else begin
            RegWrite  <= 1'b0;
        end
    end

    always_comb begin
        rsQueued = 1'b0;
        rtQueued = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entryValid[i] && entryRd[i] == QueryRs) rsQueued = 1'b1;
            if (entryValid[i] && entryRd[i] == QueryRt) rtQueued = 1'b1;
        end
    end

    assign RsPending = isRealReg(QueryRs) && (rsQueued || (RegWrite && rd == QueryRs));
    assign RtPending = isRealReg(QueryRt) && (rtQueued || (RegWrite && rd == QueryRt));

`ifdef WB_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] starveCount;

    // Counts cycles the queue head loses to the pipeline; saturates at the limit.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            starveCount <= '0;
        end else if (Empty || longPop) begin
            starveCount <= '0;
        end else if (aluWins && starveCount < STARVE_W'(STARVE_LIMIT)) begin
            starveCount <= starveCount + 1'b1;
        end
    end

    assign LongStarve = starveCount >= STARVE_W'(STARVE_LIMIT);
`else
    assign LongStarve = 1'b0;
`endif

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed scoreboard bench for wb_write_arbiter: stimulus queues expected writes,
// a negedge monitor pops and compares every RegWrite pulse.
module tb_wb_write_arbiter;
    import wb_write_arbiter_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        AluValid;
    logic [4:0]  AluRd;
    logic [31:0] AluData;
    logic        LongValid;
    logic [4:0]  LongRd;
    logic [31:0] LongData;
    logic        LongReady;
    logic        RegWrite;
    logic [4:0]  rd;
    logic [31:0] InputData;
    logic [4:0]  QueryRs;
    logic [4:0]  QueryRt;
    logic        RsPending;
    logic        RtPending;
    logic        LongStarve;
    logic        Full;
    logic        Empty;

    wbWrite_t expectQ[$];
    wbWrite_t monExp;
    int       checks = 0;
    int       errors = 0;
    logic     expStarve;

    wb_write_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .AluValid   (AluValid),
        .AluRd      (AluRd),
        .AluData    (AluData),
        .LongValid  (LongValid),
        .LongRd     (LongRd),
        .LongData   (LongData),
        .LongReady  (LongReady),
        .RegWrite   (RegWrite),
        .rd         (rd),
        .InputData  (InputData),
        .QueryRs    (QueryRs),
        .QueryRt    (QueryRt),
        .RsPending  (RsPending),
        .RtPending  (RtPending),
        .LongStarve (LongStarve),
        .Full       (Full),
        .Empty      (Empty)
    );

    always #5 Clock = ~Clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Drives one cycle of inputs, queues the pipeline write it should produce,
    // and returns just after the capturing posedge.
    task automatic applyStimulus(input logic aV, input logic [4:0] aR, input logic [31:0] aD,
                                 input logic lV, input logic [4:0] lR, input logic [31:0] lD);
        AluValid  = aV;
        AluRd     = aR;
        AluData   = aD;
        LongValid = lV;
        LongRd    = lR;
        LongData  = lD;
        if (aV && aR != 5'd0) expectQ.push_back('{rd: aR, data: aD});
        @(posedge Clock);
        #1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, " RegWrite"}, 32'(RegWrite), 32'd0);
        checkOutput({tag, " rd"}, 32'(rd), 32'd0);
        checkOutput({tag, " InputData"}, InputData, 32'd0);
        checkOutput({tag, " Empty"}, 32'(Empty), 32'd1);
        checkOutput({tag, " Full"}, 32'(Full), 32'd0);
        checkOutput({tag, " LongReady"}, 32'(LongReady), 32'd1);
        checkOutput({tag, " LongStarve"}, 32'(LongStarve), 32'd0);
    endtask

    always @(negedge Clock) begin
        if (Reset_n === 1'b1 && RegWrite === 1'b1) begin
            if (expectQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected write: got rd %0d data %h, required no write", rd, InputData);
            end else begin
                monExp = expectQ.pop_front();
                checkOutput("write rd", 32'(rd), 32'(monExp.rd));
                checkOutput("write data", InputData, monExp.data);
            end
        end
    end

    initial begin
        Reset_n   = 1'b0;
        AluValid  = 1'b0;
        AluRd     = '0;
        AluData   = '0;
        LongValid = 1'b0;
        LongRd    = '0;
        LongData  = '0;
        QueryRs   = '0;
        QueryRt   = '0;
`ifdef WB_STARVE_GUARD_EN
        expStarve = 1'b1;
`else
        expStarve = 1'b0;
`endif
        #12;
        checkResetValues("reset");
        Reset_n = 1'b1;
        @(posedge Clock);
        #1;

        // Single pipeline write, visible for exactly one cycle.
        applyStimulus(1, 5'd3, 32'hDEADBEEF, 0, 0, 0);
        checkOutput("alu RegWrite", 32'(RegWrite), 32'd1);
        checkOutput("alu rd", 32'(rd), 32'd3);
        checkOutput("alu data", InputData, 32'hDEADBEEF);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("alu RegWrite drop", 32'(RegWrite), 32'd0);

        // Long push with the pipeline idle: two-posedge latency, pending until retired.
        QueryRs = 5'd7;
        applyStimulus(0, 0, 0, 1, 5'd7, 32'h11);
        expectQ.push_back('{rd: 5'd7, data: 32'h11});
        checkOutput("long queued Empty", 32'(Empty), 32'd0);
        checkOutput("long queued RsPending", 32'(RsPending), 32'd1);
        checkOutput("long queued RegWrite", 32'(RegWrite), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("long out RegWrite", 32'(RegWrite), 32'd1);
        checkOutput("long out rd", 32'(rd), 32'd7);
        checkOutput("long out RsPending", 32'(RsPending), 32'd1);
        checkOutput("long out Empty", 32'(Empty), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("long retired RsPending", 32'(RsPending), 32'd0);

        // Fill the queue behind a busy pipeline, then starve it.
        for (int k = 0; k < 4; k++)
            applyStimulus(1, 5'(10 + k), 32'hA0 + 32'(k), 1, 5'(20 + k), 32'hB0 + 32'(k));
        checkOutput("fill Full", 32'(Full), 32'd1);
        checkOutput("fill LongReady", 32'(LongReady), 32'd0);
        for (int k = 0; k < 8; k++)
            applyStimulus(1, 5'(14 + k), 32'hE0 + 32'(k), 1, 5'd30, 32'hBAD);
        QueryRt = 5'd22;
        #1;
        checkOutput("starve LongStarve", 32'(LongStarve), 32'(expStarve));
        checkOutput("queued RtPending", 32'(RtPending), 32'd1);
        for (int k = 0; k < 4; k++)
            expectQ.push_back('{rd: 5'(20 + k), data: 32'hB0 + 32'(k)});
        for (int k = 0; k < 4; k++)
            applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("drained Empty", 32'(Empty), 32'd1);
        checkOutput("drained LongStarve", 32'(LongStarve), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Simultaneous requests with an empty queue: pipeline first, no bypass.
        applyStimulus(1, 5'd5, 32'h55, 1, 5'd9, 32'h99);
        expectQ.push_back('{rd: 5'd9, data: 32'h99});
        checkOutput("tie first rd", 32'(rd), 32'd5);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("tie second rd", 32'(rd), 32'd9);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("tie idle RegWrite", 32'(RegWrite), 32'd0);

        // r0 on both paths: nothing written, nothing queued, nothing pending.
        QueryRs = 5'd0;
        QueryRt = 5'd0;
        applyStimulus(1, 5'd0, 32'h1, 1, 5'd0, 32'h2);
        checkOutput("r0 RegWrite", 32'(RegWrite), 32'd0);
        checkOutput("r0 Empty", 32'(Empty), 32'd1);
        checkOutput("r0 RsPending", 32'(RsPending), 32'd0);
        checkOutput("r0 RtPending", 32'(RtPending), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Asynchronous reset with three queued entries discards everything.
        for (int k = 0; k < 3; k++)
            applyStimulus(1, 5'(11 + k), 32'hC0 + 32'(k), 1, 5'(24 + k), 32'hD0 + 32'(k));
        AluValid  = 1'b0;
        LongValid = 1'b0;
        QueryRs   = 5'd24;
        #1;
        Reset_n = 1'b0;
        #1;
        checkResetValues("midreset");
        checkOutput("midreset RsPending", 32'(RsPending), 32'd0);
        expectQ.delete();
        #1;
        Reset_n = 1'b1;
        for (int k = 0; k < 4; k++)
            applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("post reset Empty", 32'(Empty), 32'd1);
        checkOutput("scoreboard drained", 32'(expectQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
